median_window_ctrl: RTL and testbench



---
 rtl/median_pkg.sv | 23 ++
 rtl/median_window_ctrl.sv | 144 ++++++++++++++
 tb/tb_median_window_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// Shared constants and state encoding for the median filter window sequencer.
// Module-level parameters default to these values; widths are re-derived per instance.
package median_pkg;

    localparam int W           = 101;
    localparam int HALF        = (W - 1) / 2;
    localparam int DATA_LENGTH = 16;
    localparam int CNT_W       = $clog2(HALF + 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SORT  = 3'd1,
        OUT   = 3'd2,
        PAD   = 3'd3,
        CLEAR = 3'd4
    } state_t;

    // Counter width able to hold 0..HALF+1 for a window of length w.
    function automatic int cnt_width(input int w);
        return $clog2((w - 1) / 2 + 2);
    endfunction

endpackage

// File: rtl/median_window_ctrl.sv
// Sequencer for the median filter: feeds the window delay line, requests one sort
// per window position, returns medians and flushes each record with zero pads.
//
//  state | meaning
//  IDLE  | ready for a sample; accepting one shifts it into the delay line
//  SORT  | sort requested on first cycle, waiting for srt_done
//  OUT   | median presented on m_valid/m_data until m_ready
//  PAD   | shifting one zero pad into the delay line (end of record)
//  CLEAR | clearing the delay line, pulsing rec_done
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int W           = median_pkg::W,
    parameter int DATA_LENGTH = median_pkg::DATA_LENGTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    input  logic [DATA_LENGTH-1:0] s_data,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic                   dl_shift,
    output logic [DATA_LENGTH-1:0] dl_in,
    output logic                   dl_clear,
    output logic                   srt_start,
    input  logic                   srt_done,
    input  logic [DATA_LENGTH-1:0] srt_median,
    output logic                   m_valid,
    output logic [DATA_LENGTH-1:0] m_data,
    input  logic                   m_ready,
    output logic                   rec_done
);

    localparam int         N_HALF = (W - 1) / 2;
    localparam int         CW     = cnt_width(W);
    localparam logic [CW-1:0] L_FULL = CW'(N_HALF + 1);
    localparam logic [CW-1:0] PADS_INIT = CW'(N_HALF);

    state_t                 state_q, state_d;
    logic [CW-1:0]          p_q, p_d;
    logic [CW-1:0]          l_q, l_d;
    logic [CW-1:0]          pads_q, pads_d;
    logic                   flush_q, flush_d;
    logic [DATA_LENGTH-1:0] m_data_q, m_data_d;
    logic                   s_ready_q, srt_start_q, m_valid_q, pad_q, clear_q;

    logic                   accept;
    logic [CW-1:0]          l_inc;

    // s_ready_q is low during and just after reset, so nothing is accepted then.
    assign accept = (state_q == IDLE) && s_ready_q && s_valid;
    assign l_inc  = (l_q == L_FULL) ? l_q : l_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        l_d      = l_q;
        pads_d   = pads_q;
        flush_d  = flush_q;
        m_data_d = m_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    p_d = p_q + CW'(1);
                    l_d = l_inc;
                    if (s_last) begin
                        flush_d = 1'b1;
                        pads_d  = PADS_INIT;
                    end
                    if (l_inc == L_FULL) state_d = SORT;
                    else if (s_last)     state_d = PAD;
                end
            end
            SORT: begin
                if (srt_done) begin
                    m_data_d = srt_median;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (m_ready) begin
                    p_d = p_q - CW'(1);
                    if (!flush_q)          state_d = IDLE;
                    else if (pads_q != '0) state_d = PAD;
                    else                   state_d = CLEAR;
                end
            end
            PAD: begin
                pads_d = pads_q - CW'(1);
                l_d    = l_inc;
                if ((l_inc == L_FULL) && (p_q != '0)) state_d = SORT;
                else if (pads_q != CW'(1))            state_d = PAD;
                else                                  state_d = CLEAR;
            end
            CLEAR: begin
                p_d     = '0;
                l_d     = '0;
                pads_d  = '0;
                flush_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each matches the state it decodes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            p_q         <= '0;
            l_q         <= '0;
            pads_q      <= '0;
            flush_q     <= 1'b0;
            m_data_q    <= '0;
            s_ready_q   <= 1'b0;
            srt_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            pad_q       <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            l_q         <= l_d;
            pads_q      <= pads_d;
            flush_q     <= flush_d;
            m_data_q    <= m_data_d;
            s_ready_q   <= (state_d == IDLE);
            srt_start_q <= (state_d == SORT) && (state_q != SORT);
            m_valid_q   <= (state_d == OUT);
            pad_q       <= (state_d == PAD);
            clear_q     <= (state_d == CLEAR);
        end
    end

    assign s_ready   = s_ready_q;
    assign dl_shift  = accept || pad_q;
    assign dl_in     = accept ? s_data : '0;
    assign dl_clear  = clear_q;
    assign rec_done  = clear_q;
    assign srt_start = srt_start_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;

endmodule

// File: tb/tb_median_window_ctrl.sv
// Bench for median_window_ctrl with W=5: behavioural delay line and 3-cycle sorter,
// expected medians from a zero-padded sliding-window reference.
module tb_median_window_ctrl;

    localparam int W    = 5;
    localparam int HALF = (W - 1) / 2;
    localparam int DL   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic [DL-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          dl_shift;
    logic [DL-1:0] dl_in;
    logic          dl_clear;
    logic          srt_start;
    logic          srt_done;
    logic [DL-1:0] srt_median;
    logic          m_valid;
    logic [DL-1:0] m_data;
    logic          m_ready = 1'b0;
    logic          rec_done;

    int checks = 0;
    int errors = 0;

    median_window_ctrl #(.W(W), .DATA_LENGTH(DL)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .dl_shift(dl_shift), .dl_in(dl_in), .dl_clear(dl_clear),
        .srt_start(srt_start), .srt_done(srt_done), .srt_median(srt_median),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .rec_done(rec_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Delay line sharing the controller's reset.
    logic [DL-1:0] taps [W];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < W; i++) taps[i] <= '0;
        end else if (dl_clear) begin
            for (int i = 0; i < W; i++) taps[i] <= '0;
        end else if (dl_shift) begin
            for (int i = W - 1; i > 0; i--) taps[i] <= taps[i-1];
            taps[0] <= dl_in;
        end
    end

    function automatic logic [DL-1:0] tap_median();
        logic [DL-1:0] q[$];
        for (int i = 0; i < W; i++) q.push_back(taps[i]);
        q.sort();
        return q[HALF];
    endfunction

    // Sorter with programmable latency; spur_done injects stray completions.
    int   sort_lat = 3;
    int   srt_cnt;
    logic srt_busy;
    logic srt_done_m;
    logic spur_done = 1'b0;
    assign srt_done = srt_done_m | spur_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            srt_busy   <= 1'b0;
            srt_cnt    <= 0;
            srt_done_m <= 1'b0;
            srt_median <= '0;
        end else begin
            srt_done_m <= 1'b0;
            if (srt_start) begin
                srt_busy   <= 1'b1;
                srt_cnt    <= sort_lat;
                srt_median <= tap_median();
            end else if (srt_busy) begin
                if (srt_cnt <= 1) begin
                    srt_busy   <= 1'b0;
                    srt_done_m <= 1'b1;
                end else begin
                    srt_cnt <= srt_cnt - 1;
                end
            end
        end
    end

    int ready_pct  = 100;
    bit ready_hold = 1'b0;
    always @(posedge clk) begin
        #1;
        m_ready = ready_hold ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
    end

    // Observation at the falling edge.
    logic [DL-1:0] got_q[$];
    logic [DL-1:0] exp_q[$];
    int accept_cyc[$];
    int start_cyc[$];
    int clear_cyc[$];
    int n_rec_done, rec_done_cyc, last_out_cyc, n_shift, viol;
    logic          prev_mv, prev_mr;
    logic [DL-1:0] prev_md;

    always @(negedge clk) begin
        if (reset) begin
            prev_mv = 1'b0;
        end else begin
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                last_out_cyc = cyc;
            end
            if (s_valid && s_ready) accept_cyc.push_back(cyc);
            if (srt_start) start_cyc.push_back(cyc);
            if (dl_clear) clear_cyc.push_back(cyc);
            if (rec_done) begin
                n_rec_done++;
                rec_done_cyc = cyc;
            end
            if (dl_shift) n_shift++;
            if (dl_shift && dl_clear) viol++;
            if (prev_mv && !prev_mr && (!m_valid || m_data !== prev_md)) viol++;
            prev_mv = m_valid;
            prev_mr = m_ready;
            prev_md = m_data;
        end
    end

    task automatic clear_stats();
        got_q.delete(); exp_q.delete();
        accept_cyc.delete(); start_cyc.delete(); clear_cyc.delete();
        n_rec_done = 0; rec_done_cyc = 0; last_out_cyc = 0; n_shift = 0; viol = 0;
    endtask

    function automatic int ref_median(input int rec[$], input int i);
        int win[$];
        for (int k = i - HALF; k <= i + HALF; k++)
            win.push_back((k >= 0 && k < rec.size()) ? rec[k] : 0);
        win.sort();
        return win[HALF];
    endfunction

    task automatic add_expected(input int rec[$]);
        for (int i = 0; i < rec.size(); i++) exp_q.push_back(DL'(ref_median(rec, i)));
    endtask

    task automatic send_record(input int rec[$], input bit last_flag);
        for (int i = 0; i < rec.size(); i++) begin
            int t = 0;
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_data  = DL'(rec[i]);
            s_last  = last_flag && (i == rec.size() - 1);
            do begin
                @(negedge clk);
                t++;
            end while (!s_ready && t < 3000);
            if (!s_ready) begin
                errors++;
                $display("FAIL send_timeout sample %0d s_ready=%0b required 1", i, s_ready);
                break;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_rec_done(input int n);
        int t = 0;
        while (n_rec_done < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (n_rec_done !== n) begin
            errors++;
            $display("FAIL rec_done_count got %0d required %0d", n_rec_done, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({s_ready, dl_shift, dl_in, dl_clear, srt_start, m_valid, m_data, rec_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %0h required 0",
                     {s_ready, dl_shift, dl_in, dl_clear, srt_start, m_valid, m_data, rec_done});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL s_ready_deassert_cycle got %0b required 0", s_ready);
        end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL s_ready_after_reset got %0b required 1", s_ready);
        end
    endtask

    task automatic test_basic();
        int r[$];
        clear_stats();
        ready_pct = 100; sort_lat = 3;
        r = {1, 2, 3, 4, 5};
        add_expected(r);
        send_record(r, 1'b1);
        wait_rec_done(1);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_median[%0d] got %0d required %0d", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (start_cyc.size() < 1 || accept_cyc.size() < 3 || start_cyc[0] !== accept_cyc[2] + 1) begin
            errors++;
            $display("FAIL basic_first_start starts %0d accepts %0d", start_cyc.size(), accept_cyc.size());
        end
        checks++;
        if (start_cyc.size() !== 5 || n_shift !== 7) begin
            errors++;
            $display("FAIL basic_starts_shifts got %0d/%0d required 5/7", start_cyc.size(), n_shift);
        end
        checks++;
        if (rec_done_cyc <= last_out_cyc || viol !== 0) begin
            errors++;
            $display("FAIL basic_rec_done_order done %0d last_out %0d viol %0d", rec_done_cyc, last_out_cyc, viol);
        end
    endtask

    task automatic test_single();
        int r[$];
        clear_stats();
        ready_pct = 100; sort_lat = 3;
        r = {7};
        add_expected(r);
        send_record(r, 1'b1);
        wait_rec_done(1);
        checks++;
        if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
            errors++;
            $display("FAIL single_output count %0d required 1 of value %0d", got_q.size(), exp_q[0]);
        end
        checks++;
        if (start_cyc.size() !== 1 || n_shift !== 3 || accept_cyc.size() < 1 ||
            (start_cyc.size() == 1 && start_cyc[0] !== accept_cyc[0] + 3)) begin
            errors++;
            $display("FAIL single_pads starts %0d shifts %0d required 1/3 after 2 pads",
                     start_cyc.size(), n_shift);
        end
    endtask

    task automatic test_backpressure();
        int r[$];
        logic [DL-1:0] held;
        int t = 0;
        clear_stats();
        sort_lat = 3; ready_pct = 100; ready_hold = 1'b1;
        r = {10, 20, 30};
        add_expected(r);
        fork
            send_record(r, 1'b1);
            begin
                while (!m_valid && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                held = m_data;
                checks++;
                if (m_valid !== 1'b1 || held !== exp_q[0]) begin
                    errors++;
                    $display("FAIL bp_first got valid %0b data %0d required 1/%0d", m_valid, held, exp_q[0]);
                end
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== held || s_ready !== 1'b0 || dl_shift !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold cyc %0d valid %0b data %0d ready %0b shift %0b", i,
                                 m_valid, m_data, s_ready, dl_shift);
                    end
                end
                ready_hold = 1'b0;
            end
        join
        wait_rec_done(1);
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL bp_outputs got %0d values required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_slow_sorter();
        int r[$];
        clear_stats();
        ready_pct = 100; sort_lat = 20;
        @(posedge clk); #1;
        spur_done = 1'b1;
        @(posedge clk); #1;
        spur_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || got_q.size() !== 0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL spurious_done valid %0b outputs %0d ready %0b", m_valid, got_q.size(), s_ready);
        end
        r = {3, 1, 2, 8};
        add_expected(r);
        send_record(r, 1'b1);
        wait_rec_done(1);
        checks++;
        if (got_q != exp_q || start_cyc.size() !== 4) begin
            errors++;
            $display("FAIL slow_sort outputs %0d starts %0d required 4/4", got_q.size(), start_cyc.size());
        end
        sort_lat = 3;
    endtask

    task automatic test_back_to_back();
        int r1[$];
        int r2[$];
        clear_stats();
        ready_pct = 100; sort_lat = 3;
        r1 = {1, 2, 3, 4, 5};
        r2 = {9, 9, 9};
        add_expected(r1);
        add_expected(r2);
        send_record(r1, 1'b1);
        send_record(r2, 1'b1);
        wait_rec_done(2);
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL b2b_outputs got %0d values required %0d", got_q.size(), exp_q.size());
            for (int i = 0; i < got_q.size(); i++) $display("  out[%0d]=%0d", i, got_q[i]);
        end
        checks++;
        if (clear_cyc.size() < 1 || accept_cyc.size() < 6 ||
            !(clear_cyc[0] > accept_cyc[4] && clear_cyc[0] < accept_cyc[5]) || viol !== 0) begin
            errors++;
            $display("FAIL b2b_clear_between clears %0d accepts %0d viol %0d",
                     clear_cyc.size(), accept_cyc.size(), viol);
        end
    endtask

    task automatic test_reset_mid_sort();
        int r[$];
        int t = 0;
        clear_stats();
        ready_pct = 100; sort_lat = 20;
        r = {5, 6, 7};
        send_record(r, 1'b0);
        while (start_cyc.size() < 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (start_cyc.size() < 1) begin
            errors++;
            $display("FAIL mid_sort_start got %0d starts required 1", start_cyc.size());
        end
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({s_ready, dl_shift, dl_in, dl_clear, srt_start, m_valid, m_data, rec_done} !== '0) begin
            errors++;
            $display("FAIL mid_sort_reset_outputs got %0h required 0",
                     {s_ready, dl_shift, dl_in, dl_clear, srt_start, m_valid, m_data, rec_done});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        sort_lat = 3;
        clear_stats();
        r = {4, 4, 4};
        add_expected(r);
        send_record(r, 1'b1);
        wait_rec_done(1);
        checks++;
        if (got_q != exp_q) begin
            errors++;
            $display("FAIL after_reset_outputs got %0d values required %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int rec_i = 0; rec_i < 8; rec_i++) begin
            int r[$];
            int len;
            clear_stats();
            ready_pct = $urandom_range(40, 100);
            sort_lat  = $urandom_range(1, 6);
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) r.push_back($urandom_range(0, 65535));
            add_expected(r);
            send_record(r, 1'b1);
            wait_rec_done(1);
            checks++;
            if (got_q != exp_q || start_cyc.size() !== len || n_shift !== len + HALF || viol !== 0) begin
                errors++;
                $display("FAIL random_rec %0d len %0d outputs %0d starts %0d shifts %0d viol %0d",
                         rec_i, len, got_q.size(), start_cyc.size(), n_shift, viol);
            end
        end
        sort_lat = 3;
        ready_pct = 100;
    endtask

    initial begin
        clear_stats();
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_slow_sorter();
        test_back_to_back();
        test_reset_mid_sort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
